// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: latch the winning
// request, drive the ALU for one cycle, then hold the registered result until it is accepted.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  input  logic             rsp0_ready,

  input  logic             req1_valid,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  input  logic             rsp1_ready,

  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_operand_1,
  output logic [WIDTH-1:0] alu_operand_2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,

  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high. Requesters hold valid and payload stable until then, and
  // never derive valid from ready; ready here is a pure function of state,
  // last_grant and the two valids.

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q,      state_d;
  logic             gnt_id_q,     gnt_id_d;
  logic             last_grant_q, last_grant_d;
  logic [2:0]       op_q,         op_d;
  logic [WIDTH-1:0] a_q,          a_d;
  logic [WIDTH-1:0] b_q,          b_d;
  logic [WIDTH-1:0] result_q,     result_d;
  logic             zero_q,       zero_d;

  logic grant0;
  logic grant1;
  logic is_idle;
  logic is_exec;
  logic is_resp;
  logic rsp_accept;

  assign is_idle = (state_q == ST_IDLE);
  assign is_exec = (state_q == ST_EXEC);
  assign is_resp = (state_q == ST_RESP);

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = is_idle & req0_valid & grant0;
  assign req1_ready = is_idle & req1_valid & grant1;

  assign rsp0_valid  = is_resp & ~gnt_id_q;
  assign rsp1_valid  = is_resp &  gnt_id_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;

  assign rsp_accept = gnt_id_q ? rsp1_ready : rsp0_ready;

  assign alu_opcode    = is_exec ? op_q : 3'b000;
  assign alu_operand_1 = is_exec ? a_q  : '0;
  assign alu_operand_2 = is_exec ? b_q  : '0;

  assign dbg_state = state_q;

  always_comb begin
    state_d      = state_q;
    gnt_id_d     = gnt_id_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    zero_d       = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_ready) begin
          op_d         = req0_op;
          a_d          = req0_a;
          b_d          = req0_b;
          gnt_id_d     = 1'b0;
          last_grant_d = 1'b0;
          state_d      = ST_EXEC;
        end else if (req1_ready) begin
          op_d         = req1_op;
          a_d          = req1_a;
          b_d          = req1_b;
          gnt_id_d     = 1'b1;
          last_grant_d = 1'b1;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_accept) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= 3'b000;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_id_q     <= gnt_id_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to its ALU port.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp0_result, rsp1_result;
  logic         rsp0_zero, rsp1_zero;
  logic         rsp0_ready, rsp1_ready;
  logic [2:0]   alu_opcode;
  logic [W-1:0] alu_operand_1, alu_operand_2, alu_result;
  logic         alu_zero;
  logic [1:0]   dbg_state;

  int checks;
  int errors;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_ready(rsp1_ready),
    .alu_opcode(alu_opcode), .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .dbg_state(dbg_state)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU sitting beside the arbiter
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      3'b001:  alu_result = alu_operand_1 + alu_operand_2;
      3'b010:  alu_result = alu_operand_1 - alu_operand_2;
      3'b011:  alu_result = alu_operand_1 & alu_operand_2;
      3'b100:  alu_result = alu_operand_1 | alu_operand_2;
      3'b101:  alu_result = alu_operand_1 << alu_operand_2[4:0];
      3'b110:  alu_result = alu_operand_1 >> alu_operand_2[4:0];
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_op = 3'b000; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 3'b000; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req0_ready"}, {31'd0, req0_ready}, 32'd0);
    chk({tag, "_req1_ready"}, {31'd0, req1_ready}, 32'd0);
    chk({tag, "_rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
    chk({tag, "_rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
    chk({tag, "_rsp0_result"}, rsp0_result, 32'd0);
    chk({tag, "_rsp1_result"}, rsp1_result, 32'd0);
    chk({tag, "_rsp_zero"}, {30'd0, rsp1_zero, rsp0_zero}, 32'd0);
    chk({tag, "_alu_op"}, {29'd0, alu_opcode}, 32'd0);
    chk({tag, "_alu_a"}, alu_operand_1, 32'd0);
    chk({tag, "_alu_b"}, alu_operand_2, 32'd0);
  endtask

  initial begin
    logic exp_g;
    checks = 0;
    errors = 0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset state
    #1;
    chk_all_zero("reset");
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single request, no contention: req0 ADD 5+7
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'd5; req0_b = 32'd7; rsp0_ready = 1'b1;
    settle();
    chk("single_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("single_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    settle();
    chk("single_exec_op", {29'd0, alu_opcode}, 32'd1);
    chk("single_exec_a", alu_operand_1, 32'd5);
    chk("single_exec_b", alu_operand_2, 32'd7);
    chk("single_exec_rsp_valid", {31'd0, rsp0_valid}, 32'd0);
    tick();
    chk("single_rsp_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("single_rsp_result", rsp0_result, 32'd12);
    chk("single_rsp_zero", {31'd0, rsp0_zero}, 32'd0);
    chk("single_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("single_resp_alu_op", {29'd0, alu_opcode}, 32'd0);
    tick();
    chk("single_back_idle", {30'd0, dbg_state}, 32'd0);
    chk("single_idle_rsp_valid", {31'd0, rsp0_valid}, 32'd0);

    // Tie after reset: req0 SUB 3-3 vs req1 SLL 1<<4
    rst_n = 1'b0;
    settle();
    rst_n = 1'b1;
    tick();
    req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd3; req0_b = 32'd3;
    req1_valid = 1'b1; req1_op = 3'b101; req1_a = 32'd1; req1_b = 32'd4;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    settle();
    chk("tie_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("tie_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    settle();
    chk("tie_exec_op", {29'd0, alu_opcode}, 32'd2);
    chk("tie_exec_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("tie_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("tie_rsp0_result", rsp0_result, 32'd0);
    chk("tie_rsp0_zero", {31'd0, rsp0_zero}, 32'd1);
    chk("tie_rsp1_valid_in_r0", {31'd0, rsp1_valid}, 32'd0);
    chk("tie_resp_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("tie_req1_ready_next", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    settle();
    chk("tie_exec1_op", {29'd0, alu_opcode}, 32'd5);
    chk("tie_exec1_a", alu_operand_1, 32'd1);
    chk("tie_exec1_b", alu_operand_2, 32'd4);
    tick();
    chk("tie_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    chk("tie_rsp1_result", rsp1_result, 32'd16);
    chk("tie_rsp1_zero", {31'd0, rsp1_zero}, 32'd0);
    chk("tie_rsp0_valid_in_r1", {31'd0, rsp0_valid}, 32'd0);
    tick();

    // Fairness: both valid for 6 operations; req0 ADD 10+20, req1 OR f0|0f
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'd10;   req0_b = 32'd20;
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 32'hf0;   req1_b = 32'h0f;
    exp_g = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk($sformatf("fair%0d_req0_ready", k), {31'd0, req0_ready}, {31'd0, ~exp_g});
      chk($sformatf("fair%0d_req1_ready", k), {31'd0, req1_ready}, {31'd0, exp_g});
      tick();
      tick();
      chk($sformatf("fair%0d_rsp0_valid", k), {31'd0, rsp0_valid}, {31'd0, ~exp_g});
      chk($sformatf("fair%0d_rsp1_valid", k), {31'd0, rsp1_valid}, {31'd0, exp_g});
      if (exp_g) chk($sformatf("fair%0d_result", k), rsp1_result, 32'hff);
      else       chk($sformatf("fair%0d_result", k), rsp0_result, 32'd30);
      tick();
      exp_g = ~exp_g;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure: req1 SRL 0x80>>3 with rsp1_ready low for 4 cycles, req0 waiting
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 3'b110; req1_a = 32'h80; req1_b = 32'd3;
    settle();
    chk("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'd2; req0_b = 32'd2;
    settle();
    chk("bp_exec_req0_ready", {31'd0, req0_ready}, 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 4) rsp1_ready = 1'b1;
      settle();
      chk($sformatf("bp_hold%0d_valid", c), {31'd0, rsp1_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_result", c), rsp1_result, 32'h10);
      chk($sformatf("bp_hold%0d_req0_ready", c), {31'd0, req0_ready}, 32'd0);
      tick();
    end
    rsp1_ready = 1'b0;
    settle();
    chk("bp_after_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("bp_after_req0_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("bp_rsp0_result", rsp0_result, 32'd4);
    tick();

    // Reset mid-operation: req0 ADD 1+1 killed during EXEC
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'd1; req0_b = 32'd1;
    settle();
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    settle();
    chk("rst_exec_op", {29'd0, alu_opcode}, 32'd1);
    rst_n = 1'b0;
    settle();
    chk_all_zero("rst_mid");
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rst_no_rsp%0d", c), {31'd0, rsp0_valid}, 32'd0);
    end

    // Next tie grants req0; pass-through opcode 111 with a=b=9
    req0_valid = 1'b1; req0_op = 3'b111; req0_a = 32'd9; req0_b = 32'd9;
    req1_valid = 1'b1; req1_op = 3'b011; req1_a = 32'hff; req1_b = 32'h0f;
    settle();
    chk("pt_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("pt_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    settle();
    chk("pt_exec_op", {29'd0, alu_opcode}, 32'd7);
    chk("pt_exec_a", alu_operand_1, 32'd9);
    chk("pt_exec_b", alu_operand_2, 32'd9);
    tick();
    chk("pt_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("pt_rsp0_result", rsp0_result, 32'd0);
    chk("pt_rsp0_zero", {31'd0, rsp0_zero}, 32'd1);
    tick();
    chk("pt_back_idle", {30'd0, dbg_state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
